// File: rtl/pio_osr.sv
// pio_osr: PIO output shift register with MOV/PULL/OUT arbitration and FIFO refill.
// Define PIO_OSR_AUTOPULL_EN to build the autopull (REFILL) behaviour.
module pio_osr (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_pull,
  input  logic        shift_right,
  input  logic        autopull,
  input  logic [4:0]  pull_thresh,
  input  logic        pull_req,
  input  logic        pull_block,
  input  logic [31:0] x_in,
  input  logic        out_req,
  input  logic [4:0]  out_bits,
  input  logic        mov_we,
  input  logic [31:0] mov_din,
  output logic [31:0] out_data,
  output logic        done,
  output logic        stall,
  output logic [5:0]  osr_count
);
  typedef enum logic {RUN, REFILL} state_t;
  logic [31:0] r_osr, w_osr_nxt, w_out, w_taken, w_shifted;
  logic [5:0]  r_shift_cnt, w_cnt_nxt, w_n, w_rem;
  logic [6:0]  w_sum;
  logic        w_pull, w_done, w_stall;
  state_t      w_state;

  assign w_n       = {out_bits == 5'd0, out_bits};
  assign w_rem     = 6'd32 - w_n;
  assign w_sum     = {1'b0, r_shift_cnt} + {1'b0, w_n};
  assign w_taken   = shift_right ? (r_osr << w_rem) >> w_rem : r_osr >> w_rem;
  assign w_shifted = shift_right ? r_osr >> w_n : r_osr << w_n;

`ifdef PIO_OSR_AUTOPULL_EN
  logic [5:0] w_thresh;
  assign w_thresh = {pull_thresh == 5'd0, pull_thresh};
  assign w_state  = (autopull && r_shift_cnt >= w_thresh) ? REFILL : RUN;
`else
  logic w_unused;
  assign w_unused = &{1'b0, autopull, pull_thresh};
  assign w_state  = RUN;
`endif

  always_comb begin
    w_osr_nxt = r_osr;
    w_cnt_nxt = r_shift_cnt;
    w_pull    = 1'b0;
    w_done    = 1'b0;
    w_stall   = 1'b0;
    w_out     = '0;
    if (mov_we) begin
      w_osr_nxt = mov_din;
      w_cnt_nxt = '0;
      w_done    = 1'b1;
    end else if (pull_req) begin
      w_pull  = !fifo_empty;
      w_stall = fifo_empty && pull_block;
      w_done  = !w_stall;
      if (!w_stall) begin
        w_osr_nxt = fifo_empty ? x_in : fifo_dout;
        w_cnt_nxt = '0;
      end
    end else if (out_req && w_state == REFILL) begin
      // refill now, the OUT itself retries next cycle against the fresh word
      w_pull  = !fifo_empty;
      w_stall = 1'b1;
      if (!fifo_empty) begin
        w_osr_nxt = fifo_dout;
        w_cnt_nxt = '0;
      end
    end else if (out_req) begin
      w_done    = 1'b1;
      w_out     = w_taken;
      w_osr_nxt = w_shifted;
      w_cnt_nxt = w_sum > 7'd32 ? 6'd32 : w_sum[5:0];
    end
  end

  // outputs are gated so nothing strobes while reset is held
  assign fifo_pull = w_pull & reset_n;
  assign done      = w_done & reset_n;
  assign stall     = w_stall & reset_n;
  assign out_data  = reset_n ? w_out : '0;
  assign osr_count = r_shift_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_osr       <= '0;
      r_shift_cnt <= 6'd32;
    end else begin
      r_osr       <= w_osr_nxt;
      r_shift_cnt <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_pio_osr.sv
// tb_pio_osr: randomized scoreboard bench for pio_osr against an arithmetic OSR model.
module tb_pio_osr;
`ifdef PIO_OSR_AUTOPULL_EN
  localparam bit AP_EN = 1'b1;
`else
  localparam bit AP_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_n;
  logic [31:0] fifo_dout, x_in, mov_din, out_data;
  logic fifo_empty, fifo_pull, shift_right, autopull, pull_req, pull_block;
  logic out_req, mov_we, done, stall;
  logic [4:0] pull_thresh, out_bits;
  logic [5:0] osr_count;

  typedef struct {
    int cyc;
    bit pull, done, stall;
    bit [31:0] out;
    bit [5:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  bit [31:0] m_osr;
  int m_cnt;
  int cyc = 0;
  int vectors = 0, miscompares = 0;

  pio_osr dut (
    .clk(clk), .reset_n(reset_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_pull(fifo_pull), .shift_right(shift_right), .autopull(autopull),
    .pull_thresh(pull_thresh), .pull_req(pull_req), .pull_block(pull_block),
    .x_in(x_in), .out_req(out_req), .out_bits(out_bits), .mov_we(mov_we),
    .mov_din(mov_din), .out_data(out_data), .done(done), .stall(stall),
    .osr_count(osr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // drive one cycle of inputs, predict the response and advance the model
  task automatic step(input bit mw, input bit [31:0] md, input bit pr, pb, orq,
                      input bit [4:0] ob, input bit sr, ap, input bit [4:0] th,
                      input bit fe, input bit [31:0] fd, xi);
    exp_t e;
    int n, t;
    longint unsigned v, p;
    @(posedge clk); #1;
    mov_we = mw; mov_din = md; pull_req = pr; pull_block = pb; out_req = orq;
    out_bits = ob; shift_right = sr; autopull = ap; pull_thresh = th;
    fifo_empty = fe; fifo_dout = fd; x_in = xi;
    n = (ob == 0) ? 32 : int'(ob);
    t = (th == 0) ? 32 : int'(th);
    e = '{cyc: cyc, pull: 1'b0, done: 1'b0, stall: 1'b0, out: 32'd0, cnt: 6'(m_cnt)};
    if (mw) begin
      m_osr = md; m_cnt = 0; e.done = 1'b1;
    end else if (pr) begin
      if (!fe) begin
        e.pull = 1'b1; e.done = 1'b1; m_osr = fd; m_cnt = 0;
      end else if (pb) e.stall = 1'b1;
      else begin
        e.done = 1'b1; m_osr = xi; m_cnt = 0;
      end
    end else if (orq) begin
      if (AP_EN && ap && m_cnt >= t) begin
        e.stall = 1'b1;
        if (!fe) begin
          e.pull = 1'b1; m_osr = fd; m_cnt = 0;
        end
      end else begin
        v = 64'(m_osr);
        p = 64'd1 << n;
        if (sr) begin
          e.out = 32'(v % p);
          m_osr = 32'(v / p);
        end else begin
          e.out = 32'(v / (64'd1 << (32 - n)));
          m_osr = 32'((v * p) % (64'd1 << 32));
        end
        m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
        e.done = 1'b1;
      end
    end
    if (e.pull || e.done || e.stall) sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_pull || done || stall || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
        if (sb.size() == 0) chk("unexpected_response", {29'b0, fifo_pull, done, stall}, 32'd0);
        else begin
          me = sb.pop_front();
          chk("resp_cycle", cyc, me.cyc);
          chk1("fifo_pull", fifo_pull, me.pull);
          chk1("done", done, me.done);
          chk1("stall", stall, me.stall);
          chk("out_data", out_data, me.out);
          chk("osr_count", {26'b0, osr_count}, {26'b0, me.cnt});
        end
      end else chk("idle_out_data", out_data, 32'd0);
    end
  end

  initial begin
    {mov_we, pull_req, pull_block, out_req, shift_right, autopull} = '0;
    {mov_din, x_in, pull_thresh, out_bits} = '0;
    reset_n = 1'b0; fifo_empty = 1'b0; fifo_dout = 32'hDEADBEEF; pull_req = 1'b1;
    #12;
    chk1("rst_fifo_pull", fifo_pull, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_osr_count", {26'b0, osr_count}, 32'd32);
    pull_req = 1'b0; fifo_empty = 1'b1;
    m_osr = '0; m_cnt = 32;
    @(negedge clk); reset_n = 1'b1;

    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    chk1("pull_fifo_pull", fifo_pull, 1'b1);
    chk1("pull_done", done, 1'b1);
    idle();
    chk("pull_count", {26'b0, osr_count}, 32'd0);
    step(0, 0, 0, 0, 1, 8, 1, 0, 0, 1, 0, 0);
    chk("out8_data", out_data, 32'hEF);
    idle();
    chk("out8_count", {26'b0, osr_count}, 32'd8);
    step(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    chk("out32_data", out_data, 32'h00DEADBE);
    idle();
    chk("out32_count", {26'b0, osr_count}, 32'd32);

    step(1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 16, 0, 0, 0, 1, 0, 0);
    chk("msb16_data", out_data, 32'h0000DEAD);
    step(0, 0, 0, 0, 1, 4, 0, 1, 16, 0, 32'h12345678, 0);
`ifdef PIO_OSR_AUTOPULL_EN
    chk1("refill_stall", stall, 1'b1);
    chk1("refill_pull", fifo_pull, 1'b1);
`endif
    step(0, 0, 0, 0, 1, 4, 0, 1, 16, 1, 0, 0);
`ifdef PIO_OSR_AUTOPULL_EN
    chk1("refill_done", done, 1'b1);
    chk("refill_data", out_data, 32'h1);
`endif

    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5);
    chk1("xpull_done", done, 1'b1);
    chk1("xpull_no_pop", fifo_pull, 1'b0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    chk("xpull_word", out_data, 32'hA5A5A5A5);
    repeat (3) begin
      step(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      chk1("blk_stall", stall, 1'b1);
    end
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0);
    chk1("blk_release", done, 1'b1);

    step(1, 32'h0F, 1, 0, 1, 4, 1, 0, 0, 0, 32'h11111111, 0);
    chk1("prio_done", done, 1'b1);
    chk1("prio_no_pop", fifo_pull, 1'b0);
    chk("prio_out", out_data, 32'd0);
    step(0, 0, 0, 0, 1, 4, 1, 0, 0, 1, 0, 0);
    chk("prio_osr", out_data, 32'hF);

    step(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 4, 1, 1, 0, 1, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b0; fifo_empty = 1'b0; fifo_dout = 32'h55;
    @(negedge clk);
    chk1("rst_stall_no_pop", fifo_pull, 1'b0);
    chk1("rst_stall_stall", stall, 1'b0);
    chk("rst_stall_count", {26'b0, osr_count}, 32'd32);
    out_req = 1'b0; autopull = 1'b0; fifo_empty = 1'b1;
    m_osr = '0; m_cnt = 32;
    #2 reset_n = 1'b1;

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 5'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
           $urandom_range(0, 2) == 0, $urandom, $urandom);
    repeat (3) idle();
    chk("scoreboard_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
